// File: rtl/down_counter_timer.sv
// Loadable down-counter timer.
// A start value is taken over a valid/ready handshake and counted down to zero.
// done pulses for one cycle on reaching zero. With AUTO_RELOAD the count
// restarts from the last loaded value, which makes a periodic tick source.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for a load; count_out holds its last value
// RUN   | counting down while enable is high
// DONE  | single-cycle terminal state; done is high, reload or return
module down_counter_timer #(
    parameter int WIDTH       = 4,
    parameter bit AUTO_RELOAD = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_value,
    input  logic             enable,
    input  logic             abort,
    output logic [WIDTH-1:0] count_out,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             load_hs;

    // Every output except the count is a direct decode of the state.
    // reset is folded into load_ready so no load is offered while it is held.
    assign load_ready = (state_q == S_IDLE) && !abort && !reset;
    assign load_hs    = load_valid && load_ready;
    assign busy       = (state_q != S_IDLE);
    assign done       = (state_q == S_DONE);
    assign count_out  = count_q;

    // State, count and reload registers; reset clears everything at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            count_q  <= '0;
            reload_q <= '0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            reload_q <= reload_d;
        end
    end

    // Next-state and next-count selection; abort outranks decrement and reload.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        reload_d = reload_q;
        unique case (state_q)
            S_IDLE: begin
                if (load_hs) begin
                    reload_d = load_value;
                    if (load_value != '0) begin
                        count_d = load_value;
                        state_d = S_RUN;
                    end else begin
                        count_d = '0;
                        state_d = S_DONE;
                    end
                end
            end
            S_RUN: begin
                if (abort) begin
                    count_d = '0;
                    state_d = S_IDLE;
                end else if (enable) begin
                    // <= 1 rather than == 1 so the count can never wrap past zero
                    if (count_q <= WIDTH'(1)) begin
                        count_d = '0;
                        state_d = S_DONE;
                    end else begin
                        count_d = count_q - WIDTH'(1);
                    end
                end
            end
            S_DONE: begin
                if (abort) begin
                    count_d = '0;
                    state_d = S_IDLE;
                end else if (AUTO_RELOAD && (reload_q != '0)) begin
                    count_d = reload_q;
                    state_d = S_RUN;
                end else begin
                    count_d = '0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                count_d = '0;
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_down_counter_timer.sv
// Directed bench for down_counter_timer: one instance without auto-reload
// (dut_a) and one with auto-reload (dut_b), sharing clock and reset.
module tb_down_counter_timer;

    localparam int W = 4;

    logic         clk;
    logic         rst;
    logic         a_lv, a_en, a_ab, a_rdy, a_busy, a_done;
    logic [W-1:0] a_val, a_cnt;
    logic         b_lv, b_en, b_ab, b_rdy, b_busy, b_done;
    logic [W-1:0] b_val, b_cnt;

    int n_checks;
    int n_fail;

    down_counter_timer #(.WIDTH(W), .AUTO_RELOAD(1'b0)) dut_a (
        .clk(clk), .reset(rst),
        .load_valid(a_lv), .load_ready(a_rdy), .load_value(a_val),
        .enable(a_en), .abort(a_ab),
        .count_out(a_cnt), .busy(a_busy), .done(a_done)
    );

    down_counter_timer #(.WIDTH(W), .AUTO_RELOAD(1'b1)) dut_b (
        .clk(clk), .reset(rst),
        .load_valid(b_lv), .load_ready(b_rdy), .load_value(b_val),
        .enable(b_en), .abort(b_ab),
        .count_out(b_cnt), .busy(b_busy), .done(b_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int done_seen;
        int busy_cycles;
        logic [W-1:0] exp_b [10];

        n_checks = 0;
        n_fail   = 0;
        rst = 1'b1;
        a_lv = 0; a_en = 0; a_ab = 0; a_val = '0;
        b_lv = 0; b_en = 0; b_ab = 0; b_val = '0;

        // Reset state
        step(); step();
        check("rst_cnt",   8'(a_cnt),  8'd0);
        check("rst_busy",  8'(a_busy), 8'd0);
        check("rst_done",  8'(a_done), 8'd0);
        check("rst_ready", 8'(a_rdy),  8'd0);
        rst = 1'b0;
        #1;
        check("idle_ready", 8'(a_rdy), 8'd1);

        // 1: load 5, enable high
        a_lv = 1; a_val = 4'd5; a_en = 1;
        step();
        a_lv = 0;
        check("t1_load_cnt", 8'(a_cnt), 8'd5);
        busy_cycles = 0;
        done_seen   = 0;
        for (int i = 4; i >= 0; i--) begin
            if (a_busy) busy_cycles++;
            step();
            check("t1_cnt", 8'(a_cnt), 8'(i));
            if (i > 0) check("t1_no_done", 8'(a_done), 8'd0);
        end
        check("t1_done", 8'(a_done), 8'd1);
        if (a_busy) busy_cycles++;
        step();
        check("t1_done_clr", 8'(a_done), 8'd0);
        check("t1_idle_busy", 8'(a_busy), 8'd0);
        check("t1_idle_cnt", 8'(a_cnt), 8'd0);
        check("t1_busy_len", 8'(busy_cycles), 8'd6);

        // 2: load 4, pause three cycles at count 2
        a_lv = 1; a_val = 4'd4; a_en = 1;
        step();
        a_lv = 0;
        check("t2_cnt4", 8'(a_cnt), 8'd4);
        step();
        check("t2_cnt3", 8'(a_cnt), 8'd3);
        step();
        check("t2_cnt2", 8'(a_cnt), 8'd2);
        a_en = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("t2_hold", 8'(a_cnt), 8'd2);
            check("t2_hold_busy", 8'(a_busy), 8'd1);
        end
        a_en = 1;
        step();
        check("t2_cnt1", 8'(a_cnt), 8'd1);
        step();
        check("t2_cnt0", 8'(a_cnt), 8'd0);
        check("t2_done", 8'(a_done), 8'd1);
        step();
        check("t2_done_clr", 8'(a_done), 8'd0);

        // 3: load 0 goes straight to DONE
        a_lv = 1; a_val = 4'd0;
        step();
        a_lv = 0;
        check("t3_done", 8'(a_done), 8'd1);
        check("t3_cnt", 8'(a_cnt), 8'd0);
        check("t3_ready_lo", 8'(a_rdy), 8'd0);
        step();
        check("t3_done_clr", 8'(a_done), 8'd0);
        check("t3_busy", 8'(a_busy), 8'd0);
        check("t3_ready", 8'(a_rdy), 8'd1);

        // 4: auto-reload with load 3, then abort at count 1
        exp_b = '{4'd2, 4'd1, 4'd0, 4'd3, 4'd2, 4'd1, 4'd0, 4'd3, 4'd2, 4'd1};
        b_lv = 1; b_val = 4'd3; b_en = 1;
        step();
        b_lv = 0;
        check("t4_cnt3", 8'(b_cnt), 8'd3);
        for (int c = 1; c <= 10; c++) begin
            step();
            check("t4_cnt", 8'(b_cnt), 8'(exp_b[c-1]));
            check("t4_done", 8'(b_done), (c == 3 || c == 7) ? 8'd1 : 8'd0);
        end
        b_ab = 1;
        step();
        check("t4_abort_cnt", 8'(b_cnt), 8'd0);
        check("t4_abort_busy", 8'(b_busy), 8'd0);
        check("t4_abort_done", 8'(b_done), 8'd0);
        b_lv = 1; b_val = 4'd6;
        #1;
        check("t4_abort_blocks_ready", 8'(b_rdy), 8'd0);
        step();
        check("t4_abort_no_load", 8'(b_busy), 8'd0);
        check("t4_abort_no_load_cnt", 8'(b_cnt), 8'd0);
        b_ab = 0; b_lv = 0;
        step();
        check("t4_no_late_done", 8'(b_done), 8'd0);
        check("t4_ready", 8'(b_rdy), 8'd1);

        // 5: max load, async reset mid-run at count 9
        a_lv = 1; a_val = 4'd15; a_en = 1;
        step();
        a_lv = 0;
        check("t5_cnt15", 8'(a_cnt), 8'd15);
        for (int i = 0; i < 6; i++) step();
        check("t5_cnt9", 8'(a_cnt), 8'd9);
        #2;
        rst = 1;
        #1;
        check("t5_rst_cnt", 8'(a_cnt), 8'd0);
        check("t5_rst_busy", 8'(a_busy), 8'd0);
        check("t5_rst_done", 8'(a_done), 8'd0);
        check("t5_rst_ready", 8'(a_rdy), 8'd0);
        step();
        rst = 0;
        step();
        check("t5_post_done", 8'(a_done), 8'd0);
        check("t5_post_busy", 8'(a_busy), 8'd0);

        // 6: load_valid held high through a run; second load waits for IDLE
        a_lv = 1; a_val = 4'd2; a_en = 1;
        step();
        a_val = 4'd7;
        check("t6_cnt2", 8'(a_cnt), 8'd2);
        step();
        check("t6_cnt1", 8'(a_cnt), 8'd1);
        check("t6_ready_run", 8'(a_rdy), 8'd0);
        step();
        check("t6_cnt0", 8'(a_cnt), 8'd0);
        check("t6_done", 8'(a_done), 8'd1);
        check("t6_ready_done", 8'(a_rdy), 8'd0);
        step();
        check("t6_idle_cnt", 8'(a_cnt), 8'd0);
        check("t6_idle_ready", 8'(a_rdy), 8'd1);
        step();
        a_lv = 0;
        check("t6_cnt7", 8'(a_cnt), 8'd7);
        check("t6_busy7", 8'(a_busy), 8'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global time limit so the bench always ends.
    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
